// File: rtl/dac_spi_receiver.sv
// Receives 32-bit SPI frames for a quad 12-bit DAC and updates per-channel input and DAC registers.
// Optional echo of the last good frame on spi_miso is enabled by defining DAC_RX_READBACK_EN.
module dac_spi_receiver #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        spi_sck,
  input  logic        spi_mosi,
  input  logic        dac_cs,
  input  logic        dac_clr,
  output logic        spi_miso,
  output logic        frame_valid,
  output logic        frame_err,
  output logic [3:0]  frame_cmd,
  output logic [3:0]  frame_addr,
  output logic [11:0] frame_data,
  output logic [11:0] dac_a,
  output logic [11:0] dac_b,
  output logic [11:0] dac_c,
  output logic [11:0] dac_d
);

  localparam logic [2:0] SETTLE_CYCLES = 3'(SYNC_STAGES + 1);
  localparam logic [5:0] FRAME_BITS    = 6'd32;
  localparam logic [5:0] BIT_SAT       = 6'd33;

  localparam logic [3:0] CMD_WRITE_IN  = 4'b0000;
  localparam logic [3:0] CMD_UPDATE    = 4'b0001;
  localparam logic [3:0] CMD_WRITE_ALL = 4'b0011;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Input synchronizers, preset to the bus idle levels.
  logic [SYNC_STAGES-1:0] sck_sync, mosi_sync, cs_sync, clr_sync;
  logic sck_s, mosi_s, cs_s, clr_s;

  // NOTE: sequential state is always assigned with <= so every flop samples
  // pre-edge values regardless of statement order; blocking = stays in always_comb.
  always_ff @(posedge clk) begin
    if (rst) begin
      sck_sync  <= '0;
      mosi_sync <= '0;
      cs_sync   <= '1;
      clr_sync  <= '1;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spi_sck};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], dac_cs};
      clr_sync  <= {clr_sync[SYNC_STAGES-2:0], dac_clr};
    end
  end

  assign sck_s  = sck_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];
  assign cs_s   = cs_sync[SYNC_STAGES-1];
  assign clr_s  = clr_sync[SYNC_STAGES-1];

  // Edge detection is suppressed until the chains hold real samples, so a
  // dac_cs already low when rst drops is not mistaken for a new frame start.
  logic [2:0] settle_cnt;
  logic       settled;
  logic       sck_d, cs_d, mosi_d;
  logic       sck_rise, cs_rise, cs_fall;

  assign settled = (settle_cnt == SETTLE_CYCLES);

  always_ff @(posedge clk) begin
    if (rst) begin
      settle_cnt <= '0;
      sck_d      <= 1'b0;
      cs_d       <= 1'b1;
      mosi_d     <= 1'b0;
      sck_rise   <= 1'b0;
      cs_rise    <= 1'b0;
      cs_fall    <= 1'b0;
    end else begin
      sck_d  <= sck_s;
      cs_d   <= cs_s;
      mosi_d <= mosi_s;
      if (!settled) begin
        settle_cnt <= settle_cnt + 3'd1;
        sck_rise   <= 1'b0;
        cs_rise    <= 1'b0;
        cs_fall    <= 1'b0;
      end else begin
        sck_rise <= sck_s & ~sck_d;
        cs_rise  <= cs_s & ~cs_d;
        cs_fall  <= ~cs_s & cs_d;
      end
    end
  end

  state_t      state;
  logic [31:0] shift_reg;
  logic [5:0]  bit_cnt;
  logic [3:0]  rx_cmd, rx_addr;
  logic [11:0] rx_data;
  logic        good;
  logic [3:0]  ch_sel;

  assign rx_cmd  = shift_reg[23:20];
  assign rx_addr = shift_reg[19:16];
  assign rx_data = shift_reg[15:4];
  assign good    = (state == DONE) && (bit_cnt == FRAME_BITS);

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    ch_sel = '0;
    for (int i = 0; i < 4; i++) begin
      ch_sel[i] = (rx_addr == 4'(i)) || (rx_addr == 4'hF);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      shift_reg   <= '0;
      bit_cnt     <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      frame_cmd   <= '0;
      frame_addr  <= '0;
      frame_data  <= '0;
    end else begin
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (cs_fall) begin
            state     <= SHIFT;
            shift_reg <= '0;
            bit_cnt   <= '0;
          end
        end
        SHIFT: begin
          if (cs_rise) begin
            state <= DONE;
          end else if (sck_rise) begin
            shift_reg <= {shift_reg[30:0], mosi_d};
            if (bit_cnt != BIT_SAT) bit_cnt <= bit_cnt + 6'd1;
          end
        end
        DONE: begin
          if (bit_cnt == FRAME_BITS) begin
            frame_valid <= 1'b1;
            frame_cmd   <= rx_cmd;
            frame_addr  <= rx_addr;
            frame_data  <= rx_data;
          end else begin
            frame_err <= 1'b1;
          end
          // A new frame may already be starting while this one is retired.
          if (cs_fall) begin
            state     <= SHIFT;
            shift_reg <= '0;
            bit_cnt   <= '0;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic [11:0] in_reg  [4];
  logic [11:0] dac_reg [4];

  // NOTE: these register arrays are reset explicitly: the DAC must output 0
  // after reset, so they are plain flops, not a RAM that could power up random.
  always_ff @(posedge clk) begin
    if (rst || !clr_s) begin
      for (int i = 0; i < 4; i++) begin
        in_reg[i]  <= '0;
        dac_reg[i] <= '0;
      end
    end else if (good) begin
      for (int i = 0; i < 4; i++) begin
        if (ch_sel[i]) begin
          case (rx_cmd)
            CMD_WRITE_IN:  in_reg[i] <= rx_data;
            CMD_UPDATE:    dac_reg[i] <= in_reg[i];
            CMD_WRITE_ALL: begin
              in_reg[i]  <= rx_data;
              dac_reg[i] <= rx_data;
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign dac_a = dac_reg[0];
  assign dac_b = dac_reg[1];
  assign dac_c = dac_reg[2];
  assign dac_d = dac_reg[3];

`ifdef DAC_RX_READBACK_EN
  logic        sck_fall;
  logic        tx_start;
  logic [31:0] echo_reg, tx_sr, tx_word;

  assign tx_start = cs_fall && (state != SHIFT);
  // A frame retired in the same cycle a new one starts must already be echoed.
  assign tx_word  = good ? shift_reg : echo_reg;

  always_ff @(posedge clk) begin
    if (rst) sck_fall <= 1'b0;
    else     sck_fall <= settled & ~sck_s & sck_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      echo_reg <= '0;
      tx_sr    <= '0;
      spi_miso <= 1'b0;
    end else begin
      if (good) echo_reg <= shift_reg;
      if (tx_start) begin
        tx_sr    <= tx_word;
        spi_miso <= tx_word[31];
      end else if (state == SHIFT && sck_fall) begin
        tx_sr    <= {tx_sr[30:0], 1'b0};
        spi_miso <= tx_sr[30];
      end
    end
  end
`else
  logic unused_frame_bits;

  assign spi_miso          = 1'b0;
  assign unused_frame_bits = ^{shift_reg[31:24], shift_reg[3:0]};
`endif

endmodule

// File: tb/tb_dac_spi_receiver.sv
// Self-checking bench for dac_spi_receiver: table-driven frames with a scoreboard,
// plus hand-written clear, reset-abort and readback sequences.
module tb_dac_spi_receiver;

  localparam int S    = 2;
  localparam int HALF = 6;

  logic        clk = 1'b0;
  logic        rst;
  logic        spi_sck, spi_mosi, dac_cs, dac_clr;
  logic        spi_miso, frame_valid, frame_err;
  logic [3:0]  frame_cmd, frame_addr;
  logic [11:0] frame_data, dac_a, dac_b, dac_c, dac_d;

  dac_spi_receiver #(.SYNC_STAGES(S)) dut (
    .clk        (clk),
    .rst        (rst),
    .spi_sck    (spi_sck),
    .spi_mosi   (spi_mosi),
    .dac_cs     (dac_cs),
    .dac_clr    (dac_clr),
    .spi_miso   (spi_miso),
    .frame_valid(frame_valid),
    .frame_err  (frame_err),
    .frame_cmd  (frame_cmd),
    .frame_addr (frame_addr),
    .frame_data (frame_data),
    .dac_a      (dac_a),
    .dac_b      (dac_b),
    .dac_c      (dac_c),
    .dac_d      (dac_d)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] word;
    int          nbits;
    logic        valid;
    logic [3:0]  cmd;
    logic [3:0]  addr;
    logic [11:0] data;
    logic [11:0] a, b, c, d;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  vec_t        vecs[11];
  vec_t        sb_q[$];
  logic [31:0] miso_cap;

  function automatic vec_t mk(input logic [31:0] word, input int nbits, input logic valid,
                              input logic [3:0] cmd, input logic [3:0] addr, input logic [11:0] data,
                              input logic [11:0] a, input logic [11:0] b,
                              input logic [11:0] c, input logic [11:0] d);
    vec_t v;
    v.word = word; v.nbits = nbits; v.valid = valid;
    v.cmd = cmd; v.addr = addr; v.data = data;
    v.a = a; v.b = b; v.c = c; v.d = d;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic shift_bits(input logic [31:0] word, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = (i < 32) ? word[31-i] : 1'b0;
      wait_clks(HALF);
      if (i < 32) miso_cap[31-i] = spi_miso;
      spi_sck = 1'b1;
      wait_clks(HALF);
      spi_sck = 1'b0;
    end
  endtask

  // Releases dac_cs, waits for the response pulse and compares it to the scoreboard head.
  task automatic finish_frame(input logic clr_at_end);
    int   lat;
    int   extra;
    vec_t e;
    lat   = -1;
    extra = 0;
    wait_clks(HALF);
    dac_cs = 1'b1;
    if (clr_at_end) dac_clr = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (frame_valid || frame_err) begin
        lat = k;
        break;
      end
    end
    if (lat < 0) begin
      check("pulse_timeout", 32'd0, 32'd1);
      if (sb_q.size() > 0) void'(sb_q.pop_front());
    end else begin
      e = sb_q.pop_front();
      check("latency", 32'(lat), 32'(S + 2));
      check("frame_valid", {31'd0, frame_valid}, {31'd0, e.valid});
      check("frame_err", {31'd0, frame_err}, {31'd0, ~e.valid});
      check("frame_cmd", {28'd0, frame_cmd}, {28'd0, e.cmd});
      check("frame_addr", {28'd0, frame_addr}, {28'd0, e.addr});
      check("frame_data", {20'd0, frame_data}, {20'd0, e.data});
      check("dac_a", {20'd0, dac_a}, {20'd0, e.a});
      check("dac_b", {20'd0, dac_b}, {20'd0, e.b});
      check("dac_c", {20'd0, dac_c}, {20'd0, e.c});
      check("dac_d", {20'd0, dac_d}, {20'd0, e.d});
`ifndef DAC_RX_READBACK_EN
      check("miso_const", {31'd0, spi_miso}, 32'd0);
`endif
      repeat (4) begin
        @(posedge clk); #1;
        if (frame_valid || frame_err) extra++;
      end
      check("single_pulse", 32'(extra), 32'd0);
    end
    @(negedge clk);
    dac_clr = 1'b1;
  endtask

  task automatic run_frame(input vec_t v, input logic clr_at_end);
    sb_q.push_back(v);
    dac_cs = 1'b0;
    wait_clks(HALF);
    shift_bits(v.word, v.nbits);
    finish_frame(clr_at_end);
    wait_clks(4);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int pulses;

    vecs[0]  = mk(32'h0030ABC0, 32, 1'b1, 4'h3, 4'h0, 12'hABC, 12'hABC, 12'h000, 12'h000, 12'h000);
    vecs[1]  = mk(32'h00011230, 32, 1'b1, 4'h0, 4'h1, 12'h123, 12'hABC, 12'h000, 12'h000, 12'h000);
    vecs[2]  = mk(32'h00110000, 32, 1'b1, 4'h1, 4'h1, 12'h000, 12'hABC, 12'h123, 12'h000, 12'h000);
    vecs[3]  = mk(32'hFFFFFFFF, 31, 1'b0, 4'h1, 4'h1, 12'h000, 12'hABC, 12'h123, 12'h000, 12'h000);
    vecs[4]  = mk(32'h0030FFF0, 33, 1'b0, 4'h1, 4'h1, 12'h000, 12'hABC, 12'h123, 12'h000, 12'h000);
    vecs[5]  = mk(32'h00532220, 32, 1'b1, 4'h5, 4'h3, 12'h222, 12'hABC, 12'h123, 12'h000, 12'h000);
    vecs[6]  = mk(32'h00377770, 32, 1'b1, 4'h3, 4'h7, 12'h777, 12'hABC, 12'h123, 12'h000, 12'h000);
    vecs[7]  = mk(32'h00024560, 32, 1'b1, 4'h0, 4'h2, 12'h456, 12'hABC, 12'h123, 12'h000, 12'h000);
    vecs[8]  = mk(32'h001F0000, 32, 1'b1, 4'h1, 4'hF, 12'h000, 12'hABC, 12'h123, 12'h456, 12'h000);
    vecs[9]  = mk(32'h00000000,  0, 1'b0, 4'h1, 4'hF, 12'h000, 12'hABC, 12'h123, 12'h456, 12'h000);
    vecs[10] = mk(32'h003FFFF0, 32, 1'b1, 4'h3, 4'hF, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF);

    rst = 1'b1; spi_sck = 1'b0; spi_mosi = 1'b0; dac_cs = 1'b1; dac_clr = 1'b1;
    miso_cap = '0;
    wait_clks(4);
    check("rst_valid", {31'd0, frame_valid}, 32'd0);
    check("rst_err", {31'd0, frame_err}, 32'd0);
    check("rst_miso", {31'd0, spi_miso}, 32'd0);
    check("rst_dacs", {dac_a, dac_b, 8'd0}, 32'd0);
    check("rst_fields", {frame_cmd, frame_addr, frame_data, dac_c, dac_d[11:8]}, 32'd0);
    rst = 1'b0;
    wait_clks(10);

    for (int i = 0; i < 11; i++) run_frame(vecs[i], 1'b0);

    // Clear held low for 10 cycles forces every channel to zero.
    dac_clr = 1'b0;
    wait_clks(10);
    check("clr_dac_a", {20'd0, dac_a}, 32'd0);
    check("clr_dac_d", {20'd0, dac_d}, 32'd0);
    dac_clr = 1'b1;
    wait_clks(8);
    check("clr_hold", {dac_a, dac_b, 8'd0}, 32'd0);
    check("clr_hold_cd", {dac_c, dac_d, 8'd0}, 32'd0);

    // Clear overlapping DONE beats the write-all command.
    run_frame(mk(32'h003F3210, 32, 1'b1, 4'h3, 4'hF, 12'h321, 12'h0, 12'h0, 12'h0, 12'h0), 1'b1);
    wait_clks(8);
    check("clr_done_after", {dac_a, dac_b, 8'd0}, 32'd0);

    // Echo source frame, then a frame during which the echo is shifted out.
    run_frame(mk(32'h12345678, 32, 1'b1, 4'h3, 4'h4, 12'h567, 12'h0, 12'h0, 12'h0, 12'h0), 1'b0);
    run_frame(mk(32'h00A10000, 32, 1'b1, 4'hA, 4'h1, 12'h000, 12'h0, 12'h0, 12'h0, 12'h0), 1'b0);
`ifdef DAC_RX_READBACK_EN
    check("readback_word", miso_cap, 32'h12345678);
`endif

    // rst in the middle of a frame discards it and clears the frame fields.
    dac_cs = 1'b0;
    wait_clks(HALF);
    shift_bits(32'h00325550, 16);
    rst = 1'b1;
    wait_clks(2);
    rst = 1'b0;
    check("midrst_cmd", {28'd0, frame_cmd}, 32'd0);
    check("midrst_addr", {28'd0, frame_addr}, 32'd0);
    shift_bits(32'h55500000, 16);
    wait_clks(HALF);
    dac_cs = 1'b1;
    pulses = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      if (frame_valid || frame_err) pulses++;
    end
    check("midrst_no_pulse", 32'(pulses), 32'd0);
    check("midrst_dac_c", {20'd0, dac_c}, 32'd0);
    @(negedge clk);
    wait_clks(4);
    run_frame(mk(32'h00325550, 32, 1'b1, 4'h3, 4'h2, 12'h555, 12'h0, 12'h0, 12'h555, 12'h0), 1'b0);

    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
